// File: rtl/regfile_wb_arbiter.sv
// Two-port (ALU/LSU) register-file writeback arbiter with a pending-write scoreboard.
// Define WB_FIXED_PRIO_EN for fixed LSU priority; the default build is round-robin.
module regfile_wb_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_req,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_gnt,
  input  logic            lsu_req,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            lsu_gnt,
  output logic            wr_en,
  output logic [4:0]      wr_addr,
  output logic [XLEN-1:0] wr_data,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic            rs1_busy,
  output logic            rs2_busy
);

  logic            wr_en_q, wr_en_d;
  logic [4:0]      wr_addr_q, wr_addr_d;
  logic [XLEN-1:0] wr_data_q, wr_data_d;
  logic [31:0]     busy_q, busy_d;

`ifdef WB_FIXED_PRIO_EN
  // LSU always wins contention; the ALU only gets the port when the LSU is idle.
  always_comb begin
    lsu_gnt = 1'b0;
    alu_gnt = 1'b0;
    if (!reset) begin
      lsu_gnt = lsu_req;
      alu_gnt = alu_req && !lsu_req;
    end
  end
`else
  // ptr_q: 0 prefers LSU, 1 prefers ALU; it always points away from the last winner.
  logic ptr_q, ptr_d;

  always_comb begin
    lsu_gnt = 1'b0;
    alu_gnt = 1'b0;
    if (!reset) begin
      lsu_gnt = lsu_req && (!alu_req || !ptr_q);
      alu_gnt = alu_req && (!lsu_req || ptr_q);
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (lsu_gnt)      ptr_d = 1'b1;
    else if (alu_gnt) ptr_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end
`endif

  // Writes to r0 are granted but never strobed, so r0 stays hardwired to zero.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (lsu_gnt) begin
      wr_en_d   = (lsu_rd != 5'd0);
      wr_addr_d = lsu_rd;
      wr_data_d = lsu_data;
    end else if (alu_gnt) begin
      wr_en_d   = (alu_rd != 5'd0);
      wr_addr_d = alu_rd;
      wr_data_d = alu_data;
    end
  end

  // Set is applied after clear so a newly issued write to the same index stays pending.
  always_comb begin
    busy_d = busy_q;
    if (wr_en_q) busy_d[wr_addr_q] = 1'b0;
    if (issue_valid && (issue_rd != 5'd0)) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= 5'd0;
      wr_data_q <= '0;
      busy_q    <= 32'd0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign rs1_busy = busy_q[rs1_addr];
  assign rs2_busy = busy_q[rs2_addr];

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, register data width.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port alu_req  input  1  ALU writeback request; held with payload until granted.
REQ-005 SHALL have port alu_rd  input  5  ALU destination register index.
REQ-006 SHALL have port alu_data  input  XLEN  ALU writeback data.
REQ-007 SHALL have port alu_gnt  output  1  ALU request accepted this cycle.
REQ-008 SHALL have port lsu_req  input  1  load writeback request; held with payload until granted.
REQ-009 SHALL have port lsu_rd  input  5  load destination register index.
REQ-010 SHALL have port lsu_data  input  XLEN  load writeback data.
REQ-011 SHALL have port lsu_gnt  output  1  LSU request accepted this cycle.
REQ-012 SHALL have port wr_en  output  1  register file write strobe, registered.
REQ-013 SHALL have port wr_addr  output  5  register file write index, registered.
REQ-014 SHALL have port wr_data  output  XLEN  register file write data, registered.
REQ-015 SHALL have port issue_valid  input  1  decode issued an instruction that writes issue_rd.
REQ-016 SHALL have port issue_rd  input  5  destination of the issued instruction.
REQ-017 SHALL have ports rs1_addr, rs2_addr  input  5 each  source indices queried by decode.
REQ-018 SHALL have ports rs1_busy, rs2_busy  output  1 each  combinational pending-write flag for rs1_addr/rs2_addr.

Function
REQ-019 SHALL grant at most one requester per cycle; alu_gnt and lsu_gnt combinational from requests and priority pointer.
REQ-020 SHALL arbitrate round-robin: pointer names the preferred requester, toggles to the other after every grant; after reset it prefers LSU.
REQ-021 SHALL grant a lone requester in the same cycle regardless of pointer.
REQ-022 SHALL, one cycle after a grant, drive wr_en=1, wr_addr=granted rd, wr_data=granted data for exactly one cycle; wr_en=0 in cycles with no grant.
REQ-023 SHALL grant a request with rd=0 normally but keep wr_en=0 for it (r0 hardwired zero); pointer still advances.
REQ-024 SHALL keep a 32-bit busy vector; bit 0 permanently 0.
REQ-025 SHALL set busy[issue_rd] at the clock edge when issue_valid=1 and issue_rd!=0.
REQ-026 SHALL clear busy[wr_addr] at the clock edge when wr_en=1.
REQ-027 SHALL, when set and clear target the same index in the same cycle, leave the bit set (newer pending write wins).
REQ-028 SHALL drive rsN_busy = busy[rsN_addr]; no bypass of the concurrent wr_en.
REQ-029 SHALL sustain one write per cycle under continuous requests (no bubbles).

Reset
REQ-030 SHALL, while reset=1, force wr_en=0, wr_addr=0, wr_data=0, busy vector all zero, pointer to LSU, independent of clk.
REQ-031 SHALL drop a request granted in the cycle reset asserts; no write emerges after reset release.
REQ-032 SHALL hold alu_gnt=lsu_gnt=0 while reset=1.

Configuration
REQ-033 SHALL, with macro WB_FIXED_PRIO_EN defined, use fixed priority: LSU always wins contention, pointer logic removed.
REQ-034 SHALL, without WB_FIXED_PRIO_EN, use round-robin per REQ-020.

Verification
REQ-035 SHALL cover: both request after reset (alu_rd=5/0xAAAA, lsu_rd=6/0xBBBB) -> lsu_gnt cycle 0, alu_gnt cycle 1; writes r6=0xBBBB then r5=0xAAAA on consecutive cycles.
REQ-036 SHALL cover: issue_valid with issue_rd=7, then ALU write rd=7 -> rs1_busy=1 for rs1_addr=7 until the cycle after wr_en with wr_addr=7, then 0.
REQ-037 SHALL cover: same-cycle issue_rd=9 and wr_en with wr_addr=9 -> busy[9] remains 1.
REQ-038 SHALL cover: lsu_req with lsu_rd=0, data 0x1234 -> lsu_gnt=1, wr_en stays 0, busy[0] stays 0.
REQ-039 SHALL cover: reset asserted mid-grant with busy[3]=1 -> wr_en=0 immediately, busy cleared, pointer at LSU; with WB_FIXED_PRIO_EN, 4 cycles of contention -> LSU granted all 4.
